// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// A grant is held for a whole frame (req_last) or until MAX_BURST bytes are sent.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                       clock100,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [GW-1:0]     r_rr_ptr;
    logic [GW-1:0]     r_grant_id;
    logic              r_grant_active;
    logic [7:0]        r_tx_data;
    logic              r_last_flag;
    logic [BW-1:0]     r_burst_cnt;

    logic              w_any;
    logic              w_found;
    logic [GW-1:0]     w_pick;
    logic [GW-1:0]     w_rr_next;
    logic              w_gnt_valid;
    logic              w_gnt_last;
    logic [7:0]        w_gnt_byte;
    logic [NUM_REQ-1:0] w_onehot;
    logic              w_release;

    assign w_any = |req_valid;

    // First valid requester at or after r_rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned w_sum;
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_sum = 32'(r_rr_ptr) + i;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            if (!w_found && req_valid[GW'(w_sum)]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_sum);
            end
        end
    end

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        w_gnt_byte  = '0;
        w_onehot    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GW'(i)) begin
                w_gnt_valid = req_valid[i];
                w_gnt_last  = req_last[i];
                w_gnt_byte  = req_data[8*i +: 8];
                w_onehot[i] = 1'b1;
            end
        end
    end

    assign w_release = r_last_flag || (r_burst_cnt == BW'(MAX_BURST));
    assign w_rr_next = (32'(r_grant_id) == NUM_REQ - 1) ? '0 : r_grant_id + GW'(1);

    always_ff @(posedge clock100) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = ACCEPT;
                end
            end
            ACCEPT: begin
                // With bytes already sent the frame stays locked; wait for more.
                if (w_gnt_valid) begin
                    w_state_next = START;
                end else if (r_burst_cnt == '0) begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_next = w_release ? IDLE : ACCEPT;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock100) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_tx_data      <= 8'h00;
            r_last_flag    <= 1'b0;
            r_burst_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id     <= w_pick;
                        r_grant_active <= 1'b1;
                        r_burst_cnt    <= '0;
                    end
                end
                ACCEPT: begin
                    if (w_gnt_valid) begin
                        r_tx_data   <= w_gnt_byte;
                        r_last_flag <= w_gnt_last;
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    end else if (r_burst_cnt == '0) begin
                        r_grant_active <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy && w_release) begin
                        r_rr_ptr       <= w_rr_next;
                        r_grant_active <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready    = (r_state == ACCEPT) ? w_onehot : '0;
    assign tx_start     = (r_state == START);
    assign tx_data      = r_tx_data;
    assign grant_id     = r_grant_id;
    assign grant_active = r_grant_active;

endmodule
